// File: rtl/fft_agu_seq_if.sv
// fft_agu_seq_if: bundle between the FFT AGU sequencer and its surroundings
// (address calculator, operand memory, controller).
//   master : the sequencer (fft_agu_seq)
//   slave  : controller / address calculator / memory side
// Signals:
//   start              request a transform (sampled in IDLE only)
//   adr_A_in, adr_B_in butterfly addresses returned by the address calculator
//   level, index       current butterfly coordinates to the address calculator
//   rd_en              read both operands this cycle
//   wr_en, wr_adr_A/B  write-back strobe and addresses
//   busy, done         status
//   pause              stall request, present only with FFT_AGU_PAUSE_EN
interface fft_agu_seq_if #(
  parameter int unsigned M = 9
);
  logic         start;
  logic [M-1:0] adr_A_in;
  logic [M-1:0] adr_B_in;
  logic [M-1:0] level;
  logic [M-1:0] index;
  logic         rd_en;
  logic         wr_en;
  logic [M-1:0] wr_adr_A;
  logic [M-1:0] wr_adr_B;
  logic         busy;
  logic         done;
`ifdef FFT_AGU_PAUSE_EN
  logic         pause;

  modport master (
    input  start, adr_A_in, adr_B_in, pause,
    output level, index, rd_en, wr_en, wr_adr_A, wr_adr_B, busy, done
  );
  modport slave (
    output start, adr_A_in, adr_B_in, pause,
    input  level, index, rd_en, wr_en, wr_adr_A, wr_adr_B, busy, done
  );
`else
  modport master (
    input  start, adr_A_in, adr_B_in,
    output level, index, rd_en, wr_en, wr_adr_A, wr_adr_B, busy, done
  );
  modport slave (
    output start, adr_A_in, adr_B_in,
    input  level, index, rd_en, wr_en, wr_adr_A, wr_adr_B, busy, done
  );
`endif
endinterface

// File: rtl/fft_agu_seq.sv
// fft_agu_seq: sequencer for an in-place radix-2 FFT address generation unit.
// Walks level 0..M-1 and index 0..N/2-1, presents them to the combinational
// address calculator, reads the operands, and replays the returned addresses
// BFLY_LAT cycles later as write-back addresses. After each level the read
// side idles for BFLY_LAT cycles so no read of the next level overtakes a
// pending write of the current one.
// Parameters: M (log2 FFT size), BFLY_LAT (butterfly latency, 1..4).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    fft_agu_seq_if master modport (see interface file)
// Build option: FFT_AGU_PAUSE_EN adds bus.pause, which freezes the FSM,
// counters, drain counter and write pipe and masks rd_en/wr_en/done.
module fft_agu_seq #(
  parameter int unsigned M        = 9,
  parameter int unsigned BFLY_LAT = 2
) (
  input logic           clk,
  input logic           reset,
  fft_agu_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [M-1:0] IDX_LAST   = M'((1 << (M - 1)) - 1);
  localparam logic [M-1:0] LVL_LAST   = M'(M - 1);
  localparam logic [M-1:0] ONE        = M'(1);
  localparam logic [2:0]   DRAIN_LAST = 3'(BFLY_LAT - 1);

  state_t       r_state, w_state_nxt;
  logic [M-1:0] r_level, w_level_nxt;
  logic [M-1:0] r_index, w_index_nxt;
  logic [2:0]   r_drain, w_drain_nxt;
  logic         w_rd;
  logic         w_done;
  logic         w_stall;

  // Write pipe: stage 0 captures this cycle's read, last stage drives the write.
  logic         r_pv [BFLY_LAT];
  logic [M-1:0] r_pa [BFLY_LAT];
  logic [M-1:0] r_pb [BFLY_LAT];

`ifdef FFT_AGU_PAUSE_EN
  // Pause never blocks a start request taken in IDLE.
  assign w_stall = bus.pause && (r_state != S_IDLE);
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_index_nxt = r_index;
    w_drain_nxt = r_drain;
    w_rd        = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_level_nxt = '0;
          w_index_nxt = '0;
        end
      end
      S_RUN: begin
        w_rd = 1'b1;
        if (r_index == IDX_LAST) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = '0;
        end else begin
          w_index_nxt = r_index + ONE;
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          if (r_level < LVL_LAST) begin
            w_state_nxt = S_RUN;
            w_level_nxt = r_level + ONE;
            w_index_nxt = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_drain_nxt = r_drain + 3'd1;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
        w_level_nxt = '0;
        w_index_nxt = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A stalled cycle freezes everything and issues no strobes.
    if (w_stall) begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_index_nxt = r_index;
      w_drain_nxt = r_drain;
      w_rd        = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_level <= '0;
      r_index <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_index <= w_index_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < BFLY_LAT; k++) begin
        r_pv[k] <= 1'b0;
        r_pa[k] <= '0;
        r_pb[k] <= '0;
      end
    end else if (!w_stall) begin
      r_pv[0] <= w_rd;
      r_pa[0] <= bus.adr_A_in;
      r_pb[0] <= bus.adr_B_in;
      for (int unsigned k = 1; k < BFLY_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pa[k] <= r_pa[k-1];
        r_pb[k] <= r_pb[k-1];
      end
    end
  end

  assign bus.level    = r_level;
  assign bus.index    = r_index;
  assign bus.rd_en    = w_rd;
  assign bus.wr_en    = r_pv[BFLY_LAT-1] && !w_stall;
  assign bus.wr_adr_A = r_pa[BFLY_LAT-1];
  assign bus.wr_adr_B = r_pb[BFLY_LAT-1];
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = w_done;

endmodule

// File: tb/tb_fft_agu_seq.sv
// Bench for fft_agu_seq: two instances (BFLY_LAT=2 and BFLY_LAT=4) share one
// stimulus stream. A position-based model (cycles of progress since start)
// predicts every output each cycle; literal cycle numbers pin the model.
module tb_fft_agu_seq;
  localparam int unsigned M    = 9;
  localparam int          HALF = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_agu_seq_if #(.M(M)) bus0 ();
  fft_agu_seq_if #(.M(M)) bus1 ();

  assign bus0.start = start;
  assign bus1.start = start;
`ifdef FFT_AGU_PAUSE_EN
  assign bus0.pause = pause;
  assign bus1.pause = pause;
`endif
  // Stand-in address calculator: A = index, B = index + N/2.
  assign bus0.adr_A_in = bus0.index;
  assign bus0.adr_B_in = bus0.index + 9'd256;
  assign bus1.adr_A_in = bus1.index;
  assign bus1.adr_B_in = bus1.index + 9'd256;

  fft_agu_seq #(.M(M), .BFLY_LAT(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fft_agu_seq #(.M(M), .BFLY_LAT(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [8:0] a_lvl [2], a_idx [2], a_wa [2], a_wb [2];
  logic       a_rd [2], a_wr [2], a_busy [2], a_done [2];
  assign a_lvl[0] = bus0.level;    assign a_lvl[1] = bus1.level;
  assign a_idx[0] = bus0.index;    assign a_idx[1] = bus1.index;
  assign a_wa[0]  = bus0.wr_adr_A; assign a_wa[1]  = bus1.wr_adr_A;
  assign a_wb[0]  = bus0.wr_adr_B; assign a_wb[1]  = bus1.wr_adr_B;
  assign a_rd[0]  = bus0.rd_en;    assign a_rd[1]  = bus1.rd_en;
  assign a_wr[0]  = bus0.wr_en;    assign a_wr[1]  = bus1.wr_en;
  assign a_busy[0] = bus0.busy;    assign a_busy[1] = bus1.busy;
  assign a_done[0] = bus0.done;    assign a_done[1] = bus1.done;

  // Model state: progress count (0 = idle, 1 = first RUN cycle, ...).
  int mdl_a [2]    = '{0, 0};
  bit jr [2]       = '{1'b1, 1'b1};
  int c0 [2]       = '{0, 0};
  int rdcnt [2]    = '{0, 0};
  int rd_at_done [2] = '{0, 0};
  int done_off [2] = '{0, 0};
  int lastwr [2]   = '{0, 0};
  int wr_gap [2]   = '{0, 0};

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int lat, p, last, k, off, koff;
      bit pz;
      logic [8:0] e_lvl, e_idx, e_a, e_b;
      logic e_rd, e_wr, e_busy, e_done;
      lat = lat_of(d);
      p = HALF + lat;
      last = int'(M) * p + 1;
      pz = pause && (mdl_a[d] != 0);
      e_lvl = '0; e_idx = '0; e_a = '0; e_b = '0;
      e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (mdl_a[d] != 0) begin
        e_busy = 1'b1;
        if (mdl_a[d] == last) begin
          e_lvl = 9'(M - 1);
          e_idx = 9'(HALF - 1);
          e_done = !pz;
        end else begin
          off = (mdl_a[d] - 1) % p;
          e_lvl = 9'((mdl_a[d] - 1) / p);
          e_idx = (off < HALF) ? 9'(off) : 9'(HALF - 1);
          e_rd = (off < HALF) && !pz;
        end
        k = mdl_a[d] - lat;
        if (k >= 1 && k <= int'(M) * p) begin
          koff = (k - 1) % p;
          if (koff < HALF && !pz) begin
            e_wr = 1'b1;
            e_a = 9'(koff);
            e_b = 9'(koff + HALF);
          end
        end
      end
      chk("rd_en", d, 32'(a_rd[d]), 32'(e_rd));
      chk("wr_en", d, 32'(a_wr[d]), 32'(e_wr));
      chk("busy", d, 32'(a_busy[d]), 32'(e_busy));
      chk("done", d, 32'(a_done[d]), 32'(e_done));
      chk("level", d, 32'(a_lvl[d]), 32'(e_lvl));
      chk("index", d, 32'(a_idx[d]), 32'(e_idx));
      if (e_wr || jr[d]) begin
        chk("wr_adr_A", d, 32'(a_wa[d]), 32'(e_a));
        chk("wr_adr_B", d, 32'(a_wb[d]), 32'(e_b));
      end
      if (a_rd[d] === 1'b1) rdcnt[d]++;
      if (a_wr[d] === 1'b1) lastwr[d] = cyc;
      if (a_done[d] === 1'b1) begin
        done_off[d] = cyc - c0[d];
        rd_at_done[d] = rdcnt[d];
        wr_gap[d] = cyc - lastwr[d];
      end
      if (reset) begin
        mdl_a[d] = 0;
        jr[d] = 1'b1;
      end else begin
        jr[d] = 1'b0;
        if (mdl_a[d] == 0) begin
          if (start) begin
            mdl_a[d] = 1;
            c0[d] = cyc;
            rdcnt[d] = 0;
            done_off[d] = 0;
          end
        end else if (!pz) begin
          mdl_a[d] = (mdl_a[d] == last) ? 0 : mdl_a[d] + 1;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (!bus0.busy && !bus1.busy) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("wait_idle");
  endtask

  task automatic wait_at(input int lvl, input int idx);
    bit ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (bus0.level == 9'(lvl) && bus0.index == 9'(idx) && bus0.rd_en) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) timeout("wait_at");
  endtask

  task automatic check_run(input int off0, input int off1);
    chk("done_cycle", 0, 32'(done_off[0]), 32'(off0));
    chk("done_cycle", 1, 32'(done_off[1]), 32'(off1));
    chk("rd_count", 0, 32'(rd_at_done[0]), 32'd2304);
    chk("rd_count", 1, 32'(rd_at_done[1]), 32'd2304);
    chk("last_wr_to_done", 0, 32'(wr_gap[0]), 32'd1);
    chk("last_wr_to_done", 1, 32'(wr_gap[1]), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Plain transform: done at 1 + 9*(256+LAT).
    pulse_start();
    wait_idle();
    check_run(2323, 2341);

    // Stray start during level 2 is ignored.
    pulse_start();
    wait_at(2, 10);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    check_run(2323, 2341);

    // Reset at level 3, index 100, then restart.
    pulse_start();
    wait_at(3, 100);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_rd", 0, 32'(bus0.rd_en), 32'd0);
    chk("rst_wr", 0, 32'(bus0.wr_en), 32'd0);
    chk("rst_busy", 0, 32'(bus0.busy), 32'd0);
    chk("rst_level", 0, 32'(bus0.level), 32'd0);
    chk("rst_index", 0, 32'(bus0.index), 32'd0);
    chk("rst_wr_adr_B", 0, 32'(bus0.wr_adr_B), 32'd0);
    chk("rst_busy", 1, 32'(bus1.busy), 32'd0);
    chk("rst_wr", 1, 32'(bus1.wr_en), 32'd0);
    repeat (2) @(posedge clk);
    pulse_start();
    chk("restart_rd", 0, 32'(bus0.rd_en), 32'd1);
    chk("restart_level", 0, 32'(bus0.level), 32'd0);
    chk("restart_index", 0, 32'(bus0.index), 32'd0);
    wait_idle();
    check_run(2323, 2341);

    // Start high during DONE is ignored.
    pulse_start();
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
        @(posedge clk); #1;
        if (bus0.done) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("wait_done");
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_in_done", 0, 32'(bus0.busy), 32'd0);
    wait_idle();
    chk("done_cycle", 1, 32'(done_off[1]), 32'd2341);

`ifdef FFT_AGU_PAUSE_EN
    // Ten-cycle pause at level 1, index 50 delays done by ten cycles.
    pulse_start();
    wait_at(1, 50);
    pause = 1'b1;
    #1;
    chk("pause_rd", 0, 32'(bus0.rd_en), 32'd0);
    chk("pause_index", 0, 32'(bus0.index), 32'd50);
    repeat (10) @(posedge clk);
    #1 pause = 1'b0;
    chk("pause_index_held", 0, 32'(bus0.index), 32'd50);
    wait_idle();
    check_run(2333, 2351);
`endif

    // Randomised start / reset / pause traffic, checked cycle by cycle.
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 1499) == 0);
`ifdef FFT_AGU_PAUSE_EN
      pause = ($urandom_range(0, 5) == 0);
`endif
    end
    start = 1'b0;
    reset = 1'b0;
    pause = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
